// File: rtl/sw_debouncer.sv
// -----------------------------------------------------------------------------
// sw_debouncer
//
// Purpose
//    Cleans up one mechanical switch or push-button input. The raw pin is
//    brought into the clk domain through a two-flop synchroniser. A change of
//    level is accepted only once the synchronised value has held at the new
//    level for NumTicks consecutive sample ticks. One sample tick is
//    Div = ClkRate/Baud clocks long. Any bounce back to the old level throws
//    the partially completed window away.
//
// Ports
//    clk         in   1  single clock, rising edge
//    rst         in   1  asynchronous, active-low reset
//    sw_i        in   1  raw switch input, asynchronous to clk
//    db_level_o  out  1  debounced level, decoded from the state register
//    db_tick_o   out  1  registered one-cycle pulse on each accepted 0->1 change
//
// Timing (defaults Div=10, NumTicks=3)
//    Take sw_i stable from before edge E0. The synchroniser presents it at E1,
//    and the FSM enters the WAIT state at E2. The NumTicks-th tick then falls
//    on edge E(NumTicks*Div+2). The level therefore moves NumTicks*Div+3
//    rising edges after the input settled, which is 33 edges with defaults.
// -----------------------------------------------------------------------------
module sw_debouncer #(
   parameter int ClkRate  = 10_000_000,
   parameter int Baud     = 1_000_000,
   parameter int NumTicks = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic db_level_o,
   output logic db_tick_o
);

   // Clocks per sample tick, and the widths of the two counters.
   localparam int Div  = ClkRate / Baud;
   localparam int CntW = (Div > 1) ? $clog2(Div) : 1;
   localparam int KW   = ($clog2(NumTicks + 1) > 0) ? $clog2(NumTicks + 1) : 1;

   localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
   localparam logic [KW-1:0]   KLast   = KW'(NumTicks - 1);

   // Reject parameter sets that cannot produce a sensible debounce window.
   // A one-clock tick would make the tick counter degenerate. Zero ticks
   // would accept every glitch.
   generate
      if ((Div < 2) || (NumTicks < 1)) begin : g_param_check
         $error("sw_debouncer: need ClkRate/Baud >= 2 and NumTicks >= 1");
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Two-flop synchroniser: sw_i -> sync_q[0] (s1) -> sync_q[1] (sw_s).
   // Stage 0 may go metastable. Only stage 1 is used by the logic below.
   // --------------------------------------------------------------------------
   localparam int SyncStages = 2;

   logic [SyncStages-1:0] sync_q;
   logic                  sw_s;

   genvar gi;
   generate
      for (gi = 0; gi < SyncStages; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  sync_q[gi] <= 1'b0;
               end else begin
                  sync_q[gi] <= sw_i;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  sync_q[gi] <= 1'b0;
               end else begin
                  sync_q[gi] <= sync_q[gi-1];
               end
            end
         end
      end
   endgenerate

   assign sw_s = sync_q[SyncStages-1];

   // --------------------------------------------------------------------------
   // Debounce FSM together with its tick counter (cnt) and its stable-tick
   // counter (k).
   //
   // The counters are held at zero in the stable states ZERO and ONE, so
   // every WAIT state starts its window from a clean count. A bounce back to
   // the old level is checked before the tick. This way a glitch that lands
   // on the final tick still cancels the change.
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b10,
      WAIT0 = 2'b11
   } state_t;

   state_t          state_reg;
   logic [CntW-1:0] cnt_reg;
   logic [KW-1:0]   k_reg;
   logic            rise_reg;
   logic            tick;

   // The sample tick fires on the last clock of each Div-clock period.
   assign tick = (cnt_reg == CntLast);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ZERO;
         cnt_reg   <= '0;
         k_reg     <= '0;
         rise_reg  <= 1'b0;
      end else begin
         // The rising-edge pulse lasts only one cycle unless it is set again below.
         rise_reg <= 1'b0;

         case (state_reg)
            ZERO: begin
               cnt_reg <= '0;
               k_reg   <= '0;
               if (sw_s) begin
                  state_reg <= WAIT1;
               end
            end

            WAIT1: begin
               if (!sw_s) begin
                  // The input bounced back low, so the window is abandoned.
                  state_reg <= ZERO;
                  cnt_reg   <= '0;
                  k_reg     <= '0;
               end else if (tick) begin
                  cnt_reg <= '0;
                  if (k_reg == KLast) begin
                     state_reg <= ONE;
                     k_reg     <= '0;
                     // The pulse shows in the first cycle that the level reads 1.
                     rise_reg  <= 1'b1;
                  end else begin
                     k_reg <= k_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            ONE: begin
               cnt_reg <= '0;
               k_reg   <= '0;
               if (!sw_s) begin
                  state_reg <= WAIT0;
               end
            end

            WAIT0: begin
               if (sw_s) begin
                  // The input bounced back high, so the window is abandoned.
                  state_reg <= ONE;
                  cnt_reg   <= '0;
                  k_reg     <= '0;
               end else if (tick) begin
                  cnt_reg <= '0;
                  if (k_reg == KLast) begin
                     // The falling change is accepted without a pulse.
                     state_reg <= ZERO;
                     k_reg     <= '0;
                  end else begin
                     k_reg <= k_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg <= ZERO;
               cnt_reg   <= '0;
               k_reg     <= '0;
            end
         endcase
      end
   end

   // The level is a pure decode of the state register. In both WAIT states
   // the output keeps showing the level that was last accepted.
   assign db_level_o = (state_reg == ONE) || (state_reg == WAIT0);
   assign db_tick_o  = rise_reg;

endmodule

// File: tb/tb_sw_debouncer.sv
// -----------------------------------------------------------------------------
// tb_sw_debouncer
//
// Directed bench for sw_debouncer at its default parameters (Div=10,
// NumTicks=3).
//
// A behavioural model works at the level of "how many consecutive sampled
// cycles the synchronised input has disagreed with the accepted level". The
// level flips once that run reaches NumTicks*Div+1 samples. A rising flip
// also produces a pulse.
//
// A compare process checks the DUT against this model on every falling edge.
// The directed sequence adds literal expectations for latency, pulse counts
// and the reset behaviour.
// -----------------------------------------------------------------------------
module tb_sw_debouncer;

   localparam int DIV = 10;
   localparam int NT  = 3;
   localparam int WIN = NT * DIV + 1;   // samples of the new level required
   localparam int LAT = NT * DIV + 3;   // rising edges from a settled input to the level change

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic sw_i = 1'b0;
   logic db_level_o;
   logic db_tick_o;

   int checks     = 0;
   int errors     = 0;
   int tick_count = 0;

   always #5 clk = ~clk;

   sw_debouncer dut (
      .clk        (clk),
      .rst        (rst),
      .sw_i       (sw_i),
      .db_level_o (db_level_o),
      .db_tick_o  (db_tick_o)
   );

   // Behavioural model.
   bit m_s1, m_s2, m_level, m_tick;
   int m_run;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_tick = 0; m_run = 0;
      end else begin
         m_tick = 0;
         if (m_s2 != m_level) m_run++;
         else m_run = 0;
         if (m_run == WIN) begin
            m_level = !m_level;
            m_run   = 0;
            m_tick  = m_level;
         end
         m_s2 = m_s1;
         m_s1 = sw_i;
      end
   end

   // Cycle-by-cycle comparison and pulse counting.
   always @(negedge clk) begin
      checks++;
      if (db_level_o !== m_level) begin
         errors++;
         $display("FAIL model_level t=%0t: got %b, expected %b", $time, db_level_o, m_level);
      end
      checks++;
      if (db_tick_o !== m_tick) begin
         errors++;
         $display("FAIL model_tick t=%0t: got %b, expected %b", $time, db_tick_o, m_tick);
      end
      if (db_tick_o === 1'b1) tick_count++;
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("ok   %s: %0d", name, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Count rising edges until the level reaches target. Returns -1 if the
   // budget of 200 edges expires first.
   task automatic measure(input logic target, output int edges);
      edges = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (db_level_o === target) begin
            edges = i;
            break;
         end
      end
   endtask

   int e;
   int t0;

   initial begin
      // 1. Reset with sw_i low, then 100 quiet cycles.
      cyc(3);
      check("in_reset_level", int'(db_level_o), 0);
      rst = 1'b1;
      cyc(100);
      check("idle_level", int'(db_level_o), 0);
      check("idle_ticks", tick_count, 0);

      // 2. Clean rise.
      t0 = tick_count;
      sw_i = 1'b1;
      measure(1'b1, e);
      check("rise_latency", e, LAT);
      check("rise_pulse_now", int'(db_tick_o), 1);
      cyc(10);
      check("rise_ticks", tick_count - t0, 1);

      // 3. Clean fall, with no pulse.
      t0 = tick_count;
      sw_i = 1'b0;
      measure(1'b0, e);
      check("fall_latency", e, LAT);
      cyc(10);
      check("fall_ticks", tick_count - t0, 0);

      // 4. Bounce: high for 20 cycles, low for 3, then steady high.
      t0 = tick_count;
      sw_i = 1'b1;
      cyc(20);
      sw_i = 1'b0;
      cyc(3);
      check("bounce_level", int'(db_level_o), 0);
      sw_i = 1'b1;
      measure(1'b1, e);
      check("bounce_latency", e, LAT);
      cyc(10);
      check("bounce_ticks", tick_count - t0, 1);

      // 5. Low glitch of 25 cycles while in ONE.
      t0 = tick_count;
      sw_i = 1'b0;
      cyc(25);
      sw_i = 1'b1;
      cyc(60);
      check("glitch_level", int'(db_level_o), 1);
      check("glitch_ticks", tick_count - t0, 0);

      // Boundary windows: 30 samples fall one short, and 31 samples are accepted.
      sw_i = 1'b0;
      measure(1'b0, e);
      check("fall2_latency", e, LAT);
      cyc(5);
      t0 = tick_count;
      sw_i = 1'b1;
      cyc(WIN - 1);
      sw_i = 1'b0;
      cyc(60);
      check("short_window_level", int'(db_level_o), 0);
      check("short_window_ticks", tick_count - t0, 0);
      sw_i = 1'b1;
      cyc(WIN);
      sw_i = 1'b0;
      cyc(5);
      check("exact_window_level", int'(db_level_o), 1);
      check("exact_window_ticks", tick_count - t0, 1);
      cyc(50);
      check("exact_window_fall", int'(db_level_o), 0);

      // 6. Reset asserted in the middle of WAIT1, then released with sw_i high.
      sw_i = 1'b1;
      cyc(15);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_wait1_level", int'(db_level_o), 0);
      check("rst_wait1_tick", int'(db_tick_o), 0);
      cyc(5);
      t0 = tick_count;
      rst = 1'b1;
      measure(1'b1, e);
      check("post_rst_latency", e, LAT);
      cyc(10);
      check("post_rst_ticks", tick_count - t0, 1);

      // Reset while in ONE must drop the level without waiting for a clock.
      check("pre_rst_one_level", int'(db_level_o), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_one_level", int'(db_level_o), 0);
      sw_i = 1'b0;
      cyc(3);
      t0 = tick_count;
      rst = 1'b1;
      cyc(40);
      check("rst_one_after_level", int'(db_level_o), 0);
      check("rst_one_after_ticks", tick_count - t0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
